// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
// Detects rising edges on N synchronous inputs and latches each one as a
// per-channel pending event. A round-robin scheduler offers one pending
// channel at a time to a single consumer over a valid/ready handshake.
// An edge that arrives while its channel is still pending, and is not being
// accepted in that cycle, is a drop. Drops set a sticky overrun flag and
// bump a saturating counter.
module edge_event_arbiter #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0]             d,
    input  logic [N-1:0]             en,
    output logic                     evt_valid,
    output logic [$clog2(N)-1:0]     evt_id,
    input  logic                     evt_ready,
    output logic [N-1:0]             pending,
    output logic [N-1:0]             overrun,
    output logic [CNT_W-1:0]         drop_cnt,
    input  logic                     clr_ovr
);

    localparam int IDW = $clog2(N);
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             valid_next;
    logic [IDW-1:0]   id_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_next;

    logic [N-1:0]     d_prev;
    logic [N-1:0]     rise;
    logic [N-1:0]     acc;
    logic [N-1:0]     drop;
    logic [N-1:0]     pending_next;
    logic [N-1:0]     overrun_next;
    logic [CNT_W-1:0] drop_cnt_next;

    // d_prev follows d unconditionally, so an input held high across reset
    // release does not look like an edge.
    always_ff @(posedge clk) begin
        d_prev <= d;
    end

    // Per-channel edge, accept and drop decode, plus next pending/overrun/count.
    always_comb begin
        int unsigned n_drop;
        int unsigned sum;
        n_drop       = 0;
        rise         = d & ~d_prev & en;
        acc          = '0;
        drop         = '0;
        pending_next = pending;
        for (int i = 0; i < N; i++) begin
            acc[i] = evt_valid & evt_ready & (evt_id == IDW'(i));
            if (rise[i]) begin
                pending_next[i] = 1'b1;
                if (pending[i] && !acc[i]) begin
                    drop[i] = 1'b1;
                    n_drop  = n_drop + 1;
                end
            end else if (acc[i]) begin
                pending_next[i] = 1'b0;
            end
        end
        // A drop in the same cycle as a clear survives the clear.
        if (clr_ovr) begin
            overrun_next = drop;
            sum          = n_drop;
        end else begin
            overrun_next = overrun | drop;
            sum          = int'(drop_cnt) + n_drop;
        end
        if (sum > CNT_MAX) begin
            sum = CNT_MAX;
        end
        drop_cnt_next = CNT_W'(sum);
    end

    // Channel bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending  <= '0;
            overrun  <= '0;
            drop_cnt <= '0;
        end else begin
            pending  <= pending_next;
            overrun  <= overrun_next;
            drop_cnt <= drop_cnt_next;
        end
    end

    // Scheduler next-state: pick the first pending channel at or after ptr,
    // looking only at registered pending state, then hold until accepted.
    always_comb begin
        logic found;
        int   idx;
        state_next = state;
        valid_next = evt_valid;
        id_next    = evt_id;
        ptr_next   = ptr;
        found      = 1'b0;
        idx        = 0;
        case (state)
            IDLE: begin
                for (int k = 0; k < N; k++) begin
                    idx = (int'(ptr) + k) % N;
                    if (!found && pending[idx]) begin
                        found   = 1'b1;
                        id_next = IDW'(idx);
                    end
                end
                if (found) begin
                    valid_next = 1'b1;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    valid_next = 1'b0;
                    ptr_next   = (evt_id == IDW'(N - 1)) ? '0 : evt_id + 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                valid_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Scheduler state register; reset discards any event being offered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            ptr       <= '0;
        end else begin
            state     <= state_next;
            evt_valid <= valid_next;
            evt_id    <= id_next;
            ptr       <= ptr_next;
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter
// Directed bench for edge_event_arbiter with N=4 and a 2-bit drop counter,
// so counter saturation is reachable in a few cycles.
module tb_edge_event_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] d;
    logic [3:0] en;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_ready;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic [1:0] drop_cnt;
    logic       clr_ovr;

    int checks = 0;
    int errors = 0;

    edge_event_arbiter #(
        .N     (4),
        .CNT_W (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d),
        .en        (en),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready),
        .pending   (pending),
        .overrun   (overrun),
        .drop_cnt  (drop_cnt),
        .clr_ovr   (clr_ovr)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n clock edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Two-cycle reset pulse; d is left at whatever the caller set.
    task automatic apply_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        d         = 4'b0000;
        en        = 4'b1111;
        evt_ready = 1'b0;
        clr_ovr   = 1'b0;
        tick(2);
        check_output("rst_valid",   32'(evt_valid), 32'd0);
        check_output("rst_id",      32'(evt_id),    32'd0);
        check_output("rst_pending", 32'(pending),   32'd0);
        check_output("rst_overrun", 32'(overrun),   32'd0);
        check_output("rst_cnt",     32'(drop_cnt),  32'd0);
        rst_n = 1'b1;
        tick(1);

        // Single edge on ch2 with ready high.
        evt_ready = 1'b1;
        d = 4'b0100;
        tick(1);
        check_output("t1_pending",  32'(pending),   32'b0100);
        check_output("t1_novalid",  32'(evt_valid), 32'd0);
        tick(1);
        check_output("t1_valid",    32'(evt_valid), 32'd1);
        check_output("t1_id",       32'(evt_id),    32'd2);
        tick(1);
        check_output("t1_cleared",  32'(pending),   32'd0);
        check_output("t1_valid_lo", 32'(evt_valid), 32'd0);

        // Round robin from ptr 0: ch0, ch1, ch3 together.
        d = 4'b0000;
        apply_reset();
        d = 4'b1011;
        tick(1);
        check_output("t2_pending",  32'(pending), 32'b1011);
        tick(1);
        check_output("t2_id_a",     32'(evt_id),  32'd0);
        check_output("t2_valid_a",  32'(evt_valid), 32'd1);
        tick(1);
        check_output("t2_gap_a",    32'(evt_valid), 32'd0);
        tick(1);
        check_output("t2_id_b",     32'(evt_id),  32'd1);
        tick(2);
        check_output("t2_id_c",     32'(evt_id),  32'd3);
        check_output("t2_valid_c",  32'(evt_valid), 32'd1);
        tick(1);
        check_output("t2_drained",  32'(pending), 32'd0);
        // Second burst on ch0 and ch3; ptr wrapped back to 0.
        d = 4'b0000;
        tick(1);
        d = 4'b1001;
        tick(2);
        check_output("t2_id_d",     32'(evt_id),  32'd0);
        tick(2);
        check_output("t2_id_e",     32'(evt_id),  32'd3);
        tick(1);
        check_output("t2_drained2", 32'(pending), 32'd0);

        // Backpressure: ch1 edges twice while its event is held.
        evt_ready = 1'b0;
        d = 4'b0000;
        tick(1);
        d = 4'b0010;
        tick(2);
        check_output("t3_valid",    32'(evt_valid), 32'd1);
        check_output("t3_id",       32'(evt_id),    32'd1);
        d = 4'b0000;
        tick(1);
        d = 4'b0010;
        tick(1);
        check_output("t3_id_held",  32'(evt_id),  32'd1);
        check_output("t3_overrun",  32'(overrun), 32'b0010);
        check_output("t3_cnt",      32'(drop_cnt), 32'd1);
        check_output("t3_pending",  32'(pending), 32'b0010);
        evt_ready = 1'b1;
        tick(1);
        check_output("t3_acked",    32'(pending), 32'd0);
        tick(1);
        check_output("t3_no_second", 32'(evt_valid), 32'd0);

        // Counter saturation and clear, 2-bit counter.
        d = 4'b0000;
        evt_ready = 1'b0;
        apply_reset();
        d = 4'b0010;
        tick(1);
        for (int i = 1; i <= 5; i++) begin
            d = 4'b0000;
            tick(1);
            d = 4'b0010;
            tick(1);
            if (i == 2) check_output("t4_cnt2", 32'(drop_cnt), 32'd2);
        end
        check_output("t4_sat",      32'(drop_cnt), 32'd3);
        check_output("t4_ovr",      32'(overrun),  32'b0010);
        d = 4'b0000;
        clr_ovr = 1'b1;
        tick(1);
        check_output("t4_clr_cnt",  32'(drop_cnt), 32'd0);
        check_output("t4_clr_ovr",  32'(overrun),  32'd0);
        d = 4'b0010;
        tick(1);
        clr_ovr = 1'b0;
        check_output("t4_clrdrop_cnt", 32'(drop_cnt), 32'd1);
        check_output("t4_clrdrop_ovr", 32'(overrun),  32'b0010);
        d = 4'b0000;
        tick(1);
        d = 4'b1111;
        tick(1);
        check_output("t4_mix_cnt",  32'(drop_cnt), 32'd2);
        check_output("t4_mix_pend", 32'(pending),  32'b1111);
        d = 4'b0000;
        tick(1);
        d = 4'b1111;
        tick(1);
        check_output("t4_multi_cnt", 32'(drop_cnt), 32'd3);
        check_output("t4_multi_ovr", 32'(overrun),  32'b1111);

        // Edge on ch0 during its own handshake cycle.
        d = 4'b0000;
        apply_reset();
        evt_ready = 1'b1;
        d = 4'b0001;
        tick(1);
        d = 4'b0000;
        tick(1);
        check_output("t5_valid",    32'(evt_valid), 32'd1);
        d = 4'b0001;
        tick(1);
        check_output("t5_repend",   32'(pending),  32'b0001);
        check_output("t5_nodrop",   32'(drop_cnt), 32'd0);
        check_output("t5_noovr",    32'(overrun),  32'd0);
        check_output("t5_gap",      32'(evt_valid), 32'd0);
        tick(1);
        check_output("t5_second",   32'(evt_valid), 32'd1);
        check_output("t5_second_id", 32'(evt_id),  32'd0);
        tick(1);
        check_output("t5_drained",  32'(pending),  32'd0);

        // Disabling en keeps an existing pending; new edges are masked.
        evt_ready = 1'b0;
        d = 4'b0000;
        tick(1);
        d = 4'b0100;
        tick(1);
        en = 4'b0000;
        d = 4'b0101;
        tick(1);
        check_output("en_keep",     32'(pending), 32'b0100);
        check_output("en_served",   32'(evt_id),  32'd2);
        check_output("en_valid",    32'(evt_valid), 32'd1);
        en = 4'b1111;

        // Inputs high through reset release give no events.
        d = 4'b1111;
        apply_reset();
        tick(3);
        check_output("t6_no_pend",  32'(pending),   32'd0);
        check_output("t6_no_valid", 32'(evt_valid), 32'd0);

        // Reset while offering discards the event.
        d = 4'b0000;
        tick(1);
        d = 4'b0010;
        tick(2);
        check_output("t6_offer",    32'(evt_valid), 32'd1);
        rst_n = 1'b0;
        tick(1);
        check_output("t6_rst_valid", 32'(evt_valid), 32'd0);
        check_output("t6_rst_pend",  32'(pending),   32'd0);
        check_output("t6_rst_id",    32'(evt_id),    32'd0);
        rst_n = 1'b1;
        tick(2);
        check_output("t6_after",     32'(evt_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
